// File: rtl/cordic_pkg.sv
// Shared constants for the linear CORDIC datapath: operand format, q_exp width and FSM encoding.
package cordic_pkg;
  localparam int CORDIC_FLOAT_SIZE = 24;
  localparam int CORDIC_INT_SIZE   = 8;
  localparam int QEXP_W            = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic signed [QEXP_W-1:0] qexp_t;
endpackage

// File: rtl/cordic_abs_sat.sv
// Combinational optional negate with saturation: the most negative value maps to +max.
module cordic_abs_sat #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] r
);
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXV = ~MINV;

  always_comb begin
    r = a;
    if (neg) r = (a == MINV) ? MAXV : (~a + W'(1));
  end
endmodule

// File: rtl/cordic_lin_prenorm.sv
// Pre-normalises y/x operands for cordic_linear: one bit of shift per cycle, done at capture+1+max(|e|,k).
// No backpressure: start is only sampled in IDLE; results held from done until the next capture.
module cordic_lin_prenorm
  import cordic_pkg::*;
#(
  parameter int FLOAT_SIZE = CORDIC_FLOAT_SIZE,
  parameter int INT_SIZE   = CORDIC_INT_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]  x,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]  y,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]  z,
  input  logic                            mode,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]  x_out,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]  y_out,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]  z_out,
  output logic                            mode_out,
  output logic [QEXP_W-1:0]               q_exp,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);
  localparam int W = INT_SIZE + FLOAT_SIZE;

  logic [1:0]          state;
  logic signed [W-1:0] xr, yr;
  logic [W-1:0]        zr;
  qexp_t               q, dq;
  logic                mode_r, err_r, byp;
  logic [W-1:0]        xa, ys;
  logic                x_lt1, x_norm, y_norm, x_zero;

  // Sign of x drives both: |x| for the divisor, y negated alongside to keep y/x unchanged.
  cordic_abs_sat #(.W(W)) u_xa (.a(x), .neg(x[W-1]), .r(xa));
  cordic_abs_sat #(.W(W)) u_ys (.a(y), .neg(x[W-1]), .r(ys));

  assign x_zero = (x == '0);
  assign x_lt1  = (xr[W-1:FLOAT_SIZE] == '0);
  assign x_norm = (xr[W-1:FLOAT_SIZE] == INT_SIZE'(1));
  assign y_norm = (yr[W-2:FLOAT_SIZE] == {(INT_SIZE-1){yr[W-1]}});

  // q tracks k - e directly: right shift of x lowers it, left shift of x or any y shift raises it.
  always_comb begin
    dq = '0;
    if (!x_norm) dq = x_lt1 ? qexp_t'(1) : qexp_t'(-1);
    if (!y_norm) dq = dq + qexp_t'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
      q      <= '0;
      mode_r <= 1'b0;
      err_r  <= 1'b0;
      byp    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_NORM;
            mode_r <= mode;
            err_r  <= mode && x_zero;
            byp    <= !mode || x_zero;
            q      <= '0;
            if (!mode) begin
              xr <= x;
              yr <= y;
              zr <= z;
            end else if (x_zero) begin
              xr <= '0;
              yr <= '0;
              zr <= '0;
            end else begin
              xr <= xa;
              yr <= ys;
              zr <= '0;
            end
          end
        end
        ST_NORM: begin
          if (byp || (x_norm && y_norm)) begin
            state <= ST_DONE;
          end else begin
            if (!x_norm) xr <= x_lt1 ? (xr <<< 1) : (xr >>> 1);
            if (!y_norm) yr <= yr >>> 1;
            q <= q + dq;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign x_out    = xr;
  assign y_out    = yr;
  assign z_out    = zr;
  assign q_exp    = q;
  assign mode_out = mode_r;
  assign err      = err_r;
  assign busy     = (state == ST_NORM);
  assign done     = (state == ST_DONE);
endmodule
